// File: rtl/counter_input_conditioner_pkg.sv
// Shared types and constants for the counter input conditioner.
// Used by the debounce FSM and by the top-level press decode.
package counter_input_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_RISE = 2'd1,
        S_HI   = 2'd2,
        S_FALL = 2'd3
    } db_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/counter_input_conditioner_debounce_fsm.sv
// Two-flop synchroniser followed by a debounce FSM; level only changes after
// the synchronised input has held its new value for DB_CYCLES cycles.
//
//  state  | meaning
//  S_LO   | level is 0, input is 0
//  S_RISE | level is 0, input has been 1 for cnt+1 cycles
//  S_HI   | level is 1, input is 1
//  S_FALL | level is 1, input has been 0 for cnt+1 cycles
module debounce_fsm
    import counter_input_conditioner_pkg::*;
#(
    parameter int DB_W      = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    db_state_e       state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            level_q, level_d;
    logic            rise_q, rise_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            S_LO: begin
                if (sync2_q) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!sync2_q) begin
                    state_d = S_LO;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d = S_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (!sync2_q) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (sync2_q) begin
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d = S_LO;
                        level_d = 1'b0;
                    end
                end
            end
            default: state_d = S_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/counter_input_conditioner.sv
// Conditions the up/down buttons and mode switch for the 3-bit counter.
// Define COUNTER_INPUT_CONDITIONER_AUTOREPEAT_EN to enable hold-to-repeat.
module counter_input_conditioner
    import counter_input_conditioner_pkg::*;
#(
    parameter int DB_W      = 16,
    parameter int DB_CYCLES = 50000,
    parameter int REP_DELAY = 25000000,
    parameter int REP_RATE  = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic sw_mode,
    output logic updn,
    output logic cen,
    output logic m
);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] level_b, rise_b, press, rep_fire;
    logic       level_mode, mode_rise_unused;
    logic       up_evt, dn_evt;
    logic       cen_q, cen_d;
    logic       updn_q, updn_d;

    debounce_fsm #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .din(btn_up), .level(level_b[0]), .rise(rise_b[0])
    );

    debounce_fsm #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk(clk), .rst(rst), .din(btn_dn), .level(level_b[1]), .rise(rise_b[1])
    );

    debounce_fsm #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .din(sw_mode), .level(level_mode), .rise(mode_rise_unused)
    );

    // Simultaneous rises cancel each other.
    assign press = rise_b & ~{rise_b[0], rise_b[1]};

`ifdef COUNTER_INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int REP_MAX = max_int(REP_DELAY, REP_RATE);
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]            rep_act_q, rep_act_d;

    // Down-counter loaded on the press pulse; terminal count fires a repeat
    // and reloads with the repeat period. Holding both buttons kills it.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_act_d = rep_act_q;
        rep_fire  = '0;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i]  = rep_act_q[i] & level_b[i] & ~level_b[1-i] & (rep_cnt_q[i] == '0);
            rep_act_d[i] = rep_act_q[i] & level_b[i] & ~level_b[1-i];
            if (press[i] && !level_b[1-i]) begin
                rep_act_d[i] = 1'b1;
                rep_cnt_d[i] = REP_W'(REP_DELAY - 1);
            end else if (rep_fire[i]) begin
                rep_cnt_d[i] = REP_W'(REP_RATE - 1);
            end else if (rep_act_d[i]) begin
                rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
            end else begin
                rep_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_act_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_act_q <= rep_act_d;
        end
    end
`else
    localparam int rep_params_unused = REP_DELAY + REP_RATE;
    assign rep_fire = '0;
`endif

    always_comb begin
        up_evt = press[0] | rep_fire[0];
        dn_evt = press[1] | rep_fire[1];
        cen_d  = up_evt ^ dn_evt;
        updn_d = updn_q;
        if (up_evt && !dn_evt) begin
            updn_d = DIR_UP;
        end else if (dn_evt && !up_evt) begin
            updn_d = DIR_DN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cen_q  <= 1'b0;
            updn_q <= DIR_UP;
        end else begin
            cen_q  <= cen_d;
            updn_q <= updn_d;
        end
    end

    assign cen  = cen_q;
    assign updn = updn_q;
    assign m    = level_mode;

endmodule

// File: tb/tb_counter_input_conditioner.sv
// Bench for counter_input_conditioner: directed latency scenarios plus random
// button/switch activity compared every cycle against a run-length reference.
module tb_counter_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 5;
`ifdef COUNTER_INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, btn_up, btn_dn, sw_mode;
    logic updn, cen, m;

    always #5 clk = ~clk;

    counter_input_conditioner #(
        .DB_W(16), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .sw_mode(sw_mode),
        .updn(updn), .cen(cen), .m(m)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Reference: an input is accepted once its synchronised value has differed
    // from the accepted level for DB consecutive cycles.
    logic [2:0] ms1, ms2, mlvl, mrise;
    int         mrun [3];
    logic       mcen, mupdn;
    bit         mact [2];
    int         mt [2];
    int         cyc = 0;

    task automatic model_reset();
        ms1 = '0; ms2 = '0; mlvl = '0; mrise = '0;
        for (int i = 0; i < 3; i++) mrun[i] = 0;
        mcen = 1'b0; mupdn = 1'b1;
        mact[0] = 0; mact[1] = 0;
    endtask

    task automatic model_step();
        logic [2:0] sync, plvl, prise;
        logic [1:0] prs, fire;
        logic       ue, de;
        sync = ms2;
        ms2  = ms1;
        ms1  = {sw_mode, btn_dn, btn_up};
        plvl  = mlvl;
        prise = mrise;
        for (int i = 0; i < 3; i++) begin
            mrise[i] = 1'b0;
            if (sync[i] != mlvl[i]) begin
                mrun[i]++;
                if (mrun[i] == DB) begin
                    mlvl[i]  = sync[i];
                    mrise[i] = sync[i];
                    mrun[i]  = 0;
                end
            end else begin
                mrun[i] = 0;
            end
        end
        prs[0] = prise[0] & ~prise[1];
        prs[1] = prise[1] & ~prise[0];
        fire = '0;
        if (AR) begin
            for (int b = 0; b < 2; b++) begin
                bit good;
                good = plvl[b] && !plvl[1-b];
                fire[b] = mact[b] && good && (cyc - mt[b] >= RD) && ((cyc - mt[b] - RD) % RR == 0);
                mact[b] = mact[b] && good;
                if (prs[b] && !plvl[1-b]) begin
                    mact[b] = 1;
                    mt[b]   = cyc;
                end
            end
        end
        ue = prs[0] | fire[0];
        de = prs[1] | fire[1];
        mcen = ue ^ de;
        if (ue && !de) mupdn = 1'b1;
        else if (de && !ue) mupdn = 1'b0;
        cyc++;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst) model_reset();
        chk("model_cen", cen, mcen);
        chk("model_updn", updn, mupdn);
        chk("model_m", m, mlvl[2]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int rem [3];
        rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; sw_mode = 1'b0;
        #1;
        chk("reset_updn", updn, 1);
        chk("reset_cen", cen, 0);
        chk("reset_m", m, 0);
        settle(3);
        rst = 1'b0;
        settle(10);

        // Clean press held 40 cycles, then release.
        btn_up = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (k == 40) btn_up = 1'b0;
            chk("press_cen", cen, (k == 7) || (AR && k >= 17 && k <= 46 && (k - 17) % RR == 0));
            if (k == 7) chk("press_updn", updn, 1);
        end
        settle(5);

        // Bounce on the down button.
        for (int j = 0; j < 4; j++) begin
            btn_dn = (j % 2 == 0);
            tick();
            chk("bounce_quiet", cen, 0);
        end
        btn_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("bounce_cen", cen, k == 7);
            if (k == 7) chk("bounce_updn", updn, 0);
        end
        btn_dn = 1'b0;
        settle(20);

        // Simultaneous press is discarded; re-press of down afterwards counts.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle(5);
        btn_up = 1'b1; btn_dn = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("simul_cen", cen, 0);
            chk("simul_updn", updn, 1);
        end
        btn_dn = 1'b0;
        settle(10);
        btn_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("repress_cen", cen, k == 7);
            if (k == 7) chk("repress_updn", updn, 0);
        end
        btn_up = 1'b0; btn_dn = 1'b0;
        settle(20);

        // Mode switch and a short glitch.
        sw_mode = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("mode_m", m, k >= 6);
        end
        sw_mode = 1'b0;
        settle(2);
        sw_mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("mode_glitch", m, 1);
        end

        // Async reset while the up button is mid-debounce.
        btn_up = 1'b1;
        settle(4);
        rst = 1'b1;
        #1;
        chk("arst_updn", updn, 1);
        chk("arst_cen", cen, 0);
        chk("arst_m", m, 0);
        settle(2);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("arst_press_cen", cen, k == 7);
        end
        btn_up = 1'b0;
        settle(20);

        // Random activity, reference model checks every cycle.
        for (int i = 0; i < 3; i++) rem[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    logic v;
                    v = 1'($urandom_range(0, 1));
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
                    case (i)
                        0: btn_up = v;
                        1: btn_dn = v;
                        default: sw_mode = v;
                    endcase
                end
                rem[i]--;
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        settle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
